// File: rtl/fifo_burst_streamer_pkg.sv
// Shared definitions for the burst streamer and the URAM FIFO it reads from.
// Holds the FSM state encoding and the default word width.
package fifo_burst_streamer_pkg;

    localparam int unsigned FIFO_DATA_WIDTH = 512;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StFlush  = 2'd2,
        StDone   = 2'd3
    } state_e;

endpackage

// File: rtl/fifo_burst_streamer_stream_out_reg.sv
// Registered valid/ready output stage holding one beat of data plus its last flag.
// can_load tells the producer when a new beat may be written this cycle.
module fifo_burst_streamer_stream_out_reg #(
    parameter int unsigned DATA_WIDTH = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  can_load
);

    logic                  valid_q;
    logic                  last_q;
    logic [DATA_WIDTH-1:0] data_q;

    always_comb can_load = !valid_q || out_ready;

    // Data is only written on load so it stays stable while back-pressured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            last_q  <= load_last;
            data_q  <= load_data;
        end else if (can_load) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    always_comb begin
        out_valid = valid_q;
        out_last  = last_q;
        out_data  = data_q;
    end

endmodule

// File: rtl/fifo_burst_streamer.sv
// Pops a commanded number of words from an FWFT FIFO and streams them downstream,
// flagging the final beat, pulsing done, and counting FIFO-underrun stall cycles.
module fifo_burst_streamer
    import fifo_burst_streamer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = FIFO_DATA_WIDTH,
    parameter int unsigned LEN_WIDTH   = 16,
    parameter int unsigned STALL_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [LEN_WIDTH-1:0]   cmd_len,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                   fifo_rd_busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_last,
    output logic                   done,
    output logic                   busy,
    output logic [STALL_WIDTH-1:0] stall_cycles
);

    state_e                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   remaining_q;
    logic [STALL_WIDTH-1:0] stall_q;
    logic                   can_load;
    logic                   want_pop;
    logic                   last_pop;
    logic                   accept;

    always_comb begin
        accept     = (state_q == StIdle) && cmd_valid;
        want_pop   = (state_q == StStream) && (remaining_q != '0);
        last_pop   = (remaining_q == LEN_WIDTH'(1));
        fifo_rd_en = want_pop && !fifo_rd_busy && can_load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d = (cmd_len == '0) ? StDone : StStream;
                end
            end
            StStream: begin
                if (fifo_rd_en && last_pop) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (out_valid && out_ready && out_last) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready    = (state_q == StIdle);
        busy         = (state_q != StIdle);
        done         = (state_q == StDone);
        stall_cycles = stall_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining_q <= '0;
        end else if (accept) begin
            remaining_q <= cmd_len;
        end else if (fifo_rd_en) begin
            remaining_q <= remaining_q - LEN_WIDTH'(1);
        end
    end

    // A stall only counts when the output could have taken a word but the FIFO had none.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (accept) begin
            stall_q <= '0;
        end else if (want_pop && can_load && fifo_rd_busy && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_WIDTH'(1);
        end
    end

    fifo_burst_streamer_stream_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (fifo_rd_en),
        .load_data(fifo_rd_data),
        .load_last(last_pop),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last),
        .can_load (can_load)
    );

endmodule

// File: tb/tb_fifo_burst_streamer.sv
// Randomized and directed bench for fifo_burst_streamer against a burst-level reference
// model that tracks pops, beats and stalls as plain counters over a FIFO queue.
module tb_fifo_burst_streamer;

    typedef logic [511:0] word_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [15:0]  cmd_len;
    logic         fifo_rd_en;
    word_t        fifo_rd_data;
    logic         fifo_rd_busy;
    logic         out_valid;
    logic         out_ready;
    word_t        out_data;
    logic         out_last;
    logic         done;
    logic         busy;
    logic [31:0]  stall_cycles;

    fifo_burst_streamer dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_len     (cmd_len),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .fifo_rd_busy(fifo_rd_busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .done        (done),
        .busy        (busy),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    word_t fifo_q[$];
    word_t ref_q[$];

    int    n_cmp = 0;
    int    n_err = 0;

    // Burst-level reference model.
    bit    m_active = 1'b0;
    bit    m_done_now = 1'b0;
    bit    m_accepted = 1'b0;
    int    m_len = 0;
    int    m_pops = 0;
    int    m_beats = 0;
    longint m_stall = 0;

    int    ready_mode = 0;
    bit    rnd_push = 1'b0;
    int    cyc = 0;

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic refresh_fifo();
        fifo_rd_busy = (fifo_q.size() == 0);
        fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic push_word(input word_t w);
        fifo_q.push_back(w);
        ref_q.push_back(w);
        refresh_fifo();
    endtask

    function automatic word_t rand_word();
        word_t w;
        for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_out_valid"}, word_t'(out_valid), word_t'(0));
        check({pfx, "_out_last"}, word_t'(out_last), word_t'(0));
        check({pfx, "_out_data"}, out_data, word_t'(0));
        check({pfx, "_done"}, word_t'(done), word_t'(0));
        check({pfx, "_busy"}, word_t'(busy), word_t'(0));
        check({pfx, "_cmd_ready"}, word_t'(cmd_ready), word_t'(1));
        check({pfx, "_stall"}, word_t'(stall_cycles), word_t'(0));
        check({pfx, "_rd_en"}, word_t'(fifo_rd_en), word_t'(0));
    endtask

    // One clock: check at negedge, advance model across the posedge, drive next inputs.
    task automatic cycle();
        bit exp_ov, exp_can, exp_pop, hs, stall_inc, pop_obs;
        @(negedge clk);
        exp_ov  = (m_pops > m_beats);
        exp_can = !exp_ov || out_ready;
        exp_pop = m_active && (m_pops < m_len) && (fifo_q.size() != 0) && exp_can;
        check("cmd_ready", word_t'(cmd_ready), word_t'(!m_active && !m_done_now));
        check("busy", word_t'(busy), word_t'(m_active || m_done_now));
        check("done", word_t'(done), word_t'(m_done_now));
        check("fifo_rd_en", word_t'(fifo_rd_en), word_t'(exp_pop));
        check("out_valid", word_t'(out_valid), word_t'(exp_ov));
        check("stall_cycles", word_t'(stall_cycles), word_t'(m_stall[31:0]));
        hs = exp_ov && out_ready;
        if (hs) begin
            check("ref_nonempty", word_t'(ref_q.size() != 0), word_t'(1));
            if (ref_q.size() != 0) check("out_data", out_data, ref_q[0]);
            check("out_last", word_t'(out_last), word_t'(m_beats + 1 == m_len));
        end
        stall_inc = m_active && (m_pops < m_len) && (fifo_q.size() == 0) && exp_can;
        pop_obs = fifo_rd_en;
        @(posedge clk);
        #1;
        cyc++;
        if (pop_obs && fifo_q.size() != 0) void'(fifo_q.pop_front());
        m_accepted = 1'b0;
        if (hs) begin
            m_beats++;
            if (ref_q.size() != 0) void'(ref_q.pop_front());
        end
        if (exp_pop) m_pops++;
        if (stall_inc && m_stall != 64'hFFFF_FFFF) m_stall++;
        if (m_done_now) begin
            m_done_now = 1'b0;
        end else if (m_active) begin
            if (hs && m_beats == m_len) begin
                m_active = 1'b0;
                m_done_now = 1'b1;
            end
        end else if (cmd_valid) begin
            m_accepted = 1'b1;
            m_stall = 0;
            m_len = int'(cmd_len);
            m_pops = 0;
            m_beats = 0;
            if (cmd_len == 16'd0) m_done_now = 1'b1;
            else m_active = 1'b1;
        end
        if (rnd_push && fifo_q.size() < 24 && $urandom_range(0, 2) != 0) push_word(rand_word());
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = (cyc % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        refresh_fifo();
    endtask

    task automatic start_cmd(input int len);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_len = 16'(len);
        do begin
            cycle();
            n++;
        end while (!m_accepted && n < 20);
        check("cmd_accepted", word_t'(m_accepted), word_t'(1));
        cmd_valid = 1'b0;
        cmd_len = 16'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_active || m_done_now) && n < budget) begin
            cycle();
            n++;
        end
        check("burst_finished", word_t'(m_active || m_done_now), word_t'(0));
    endtask

    initial begin
        int n;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_len = '0;
        out_ready = 1'b1;
        refresh_fifo();
        #2;
        check_reset_vals("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Four preloaded words, ready always high.
        for (int i = 0; i < 4; i++) push_word(word_t'(32'hA0 + i));
        start_cmd(4);
        wait_idle(40);
        check("t1_stall", word_t'(stall_cycles), word_t'(0));
        check("t1_fifo_left", word_t'(fifo_q.size()), word_t'(0));

        // Zero-length command.
        start_cmd(0);
        wait_idle(10);
        cycle();

        // Underrun: FIFO empty for five streaming cycles.
        start_cmd(3);
        repeat (5) cycle();
        for (int i = 0; i < 3; i++) push_word(word_t'(32'hB0 + i));
        wait_idle(40);
        check("t3_stall", word_t'(stall_cycles), word_t'(5));

        // Back-pressure pattern 1,0,0.
        ready_mode = 1;
        for (int i = 0; i < 8; i++) push_word(rand_word());
        start_cmd(8);
        wait_idle(100);
        check("t4_stall", word_t'(stall_cycles), word_t'(0));
        check("t4_fifo_left", word_t'(fifo_q.size()), word_t'(0));
        ready_mode = 0;

        // Reset in the middle of a 16-word burst.
        for (int i = 0; i < 16; i++) push_word(word_t'(32'hC0 + i));
        start_cmd(16);
        n = 0;
        while (m_pops < 5 && n < 30) begin
            cycle();
            n++;
        end
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        m_active = 1'b0;
        m_done_now = 1'b0;
        m_stall = 0;
        m_pops = 0;
        m_beats = 0;
        ref_q = fifo_q;
        check("t5_fifo_left", word_t'(fifo_q.size()), word_t'(11));
        #1 rst = 1'b0;
        start_cmd(11);
        wait_idle(60);
        check("t5_drained", word_t'(fifo_q.size()), word_t'(0));

        // cmd_valid held high with cmd_len changed mid-burst.
        for (int i = 0; i < 10; i++) push_word(rand_word());
        cmd_valid = 1'b1;
        cmd_len = 16'd2;
        cycle();
        cmd_len = 16'd7;
        wait_idle(40);
        check("t6_pops_first", word_t'(fifo_q.size()), word_t'(8));
        start_cmd(7);
        wait_idle(60);
        check("t6_fifo_left", word_t'(fifo_q.size()), word_t'(1));

        // Randomized bursts with random back-pressure and random FIFO fill.
        ready_mode = 2;
        rnd_push = 1'b1;
        for (int b = 0; b < 25; b++) begin
            start_cmd($urandom_range(0, 12));
            wait_idle(400);
            repeat ($urandom_range(0, 2)) cycle();
        end
        rnd_push = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
